// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two caches, the arbiter and the cacheline adaptor.
// The arbiter takes the slave modport; the cache/memory side takes master.
interface mem_arbiter_if #(
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;
   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;
   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_addr;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one physical-memory port between the I-cache and D-cache.
// Registered grant, latched op, response routed to the winner, one release cycle per transaction.
module mem_arbiter #(
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter bit          D_PRIORITY = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus_io,
   output logic [15:0]  conflict_cnt_o
);
   typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StRelease} state_e;

   state_e                state_q;
   logic                  last_d_q;
   logic                  rd_q;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [15:0]           cnt_q;

   logic d_req;
   logic d_win;
   logic contend;
   logic i_done;
   logic d_done;

   always_comb begin
      d_req   = bus_io.d_read | bus_io.d_write;
      d_win   = d_req && (D_PRIORITY || !bus_io.i_read || !last_d_q);
      contend = bus_io.i_read && d_req;
      i_done  = (state_q == StIBusy) && bus_io.pmem_resp;
      d_done  = (state_q == StDBusy) && bus_io.pmem_resp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         last_d_q <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (contend && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
               if (d_win) begin
                  // A simultaneous read+write is treated as a writeback.
                  state_q <= StDBusy;
                  wr_q    <= bus_io.d_write;
                  rd_q    <= !bus_io.d_write;
                  addr_q  <= bus_io.d_addr;
                  wdata_q <= bus_io.d_wdata;
               end else if (bus_io.i_read) begin
                  state_q <= StIBusy;
                  wr_q    <= 1'b0;
                  rd_q    <= 1'b1;
                  addr_q  <= bus_io.i_addr;
                  wdata_q <= '0;
               end
            end
            StIBusy: begin
               if (bus_io.pmem_resp) begin
                  state_q  <= StRelease;
                  last_d_q <= 1'b0;
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
               end
            end
            StDBusy: begin
               if (bus_io.pmem_resp) begin
                  state_q  <= StRelease;
                  last_d_q <= 1'b1;
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
               end
            end
            StRelease: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.pmem_read  = rd_q;
   assign bus_io.pmem_write = wr_q;
   assign bus_io.pmem_addr  = addr_q;
   assign bus_io.pmem_wdata = wdata_q;
   assign bus_io.i_resp     = i_done;
   assign bus_io.d_resp     = d_done;
   assign bus_io.i_rdata    = i_done ? bus_io.pmem_rdata : '0;
   assign bus_io.d_rdata    = d_done ? bus_io.pmem_rdata : '0;
   assign conflict_cnt_o    = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 1 uses D priority, instance 0 round-robin.
// A transaction-level model is checked every cycle, plus directed literal expectations.
module tb_mem_arbiter;
   localparam int LW = 256;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]         i_read_v, d_read_v, d_write_v, resp_v;
   logic [1:0][AW-1:0] i_addr_v, d_addr_v;
   logic [1:0][LW-1:0] d_wdata_v, rdata_in_v;
   logic [1:0]         pr_v, pw_v, ir_v, dr_v;
   logic [1:0][AW-1:0] pa_v;
   logic [1:0][LW-1:0] pwd_v, ird_v, drd_v;
   logic [1:0][15:0]   cnt_v;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      mem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
      assign bus.i_read     = i_read_v[k];
      assign bus.i_addr     = i_addr_v[k];
      assign bus.d_read     = d_read_v[k];
      assign bus.d_write    = d_write_v[k];
      assign bus.d_addr     = d_addr_v[k];
      assign bus.d_wdata    = d_wdata_v[k];
      assign bus.pmem_rdata = rdata_in_v[k];
      assign bus.pmem_resp  = resp_v[k];
      assign pr_v[k]        = bus.pmem_read;
      assign pw_v[k]        = bus.pmem_write;
      assign pa_v[k]        = bus.pmem_addr;
      assign pwd_v[k]       = bus.pmem_wdata;
      assign ir_v[k]        = bus.i_resp;
      assign dr_v[k]        = bus.d_resp;
      assign ird_v[k]       = bus.i_rdata;
      assign drd_v[k]       = bus.d_rdata;
      mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .D_PRIORITY(k == 1)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .bus_io         (bus.slave),
         .conflict_cnt_o (cnt_v[k])
      );
   end

   int errors = 0;
   int checks = 0;
   int ic[2] = '{0, 0};
   int dc[2] = '{0, 0};

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Model: owner 0 = none, 1 = I, 2 = D; rel marks the cycle after a completion.
   int          m_owner[2];
   bit          m_rel[2], m_wr[2], m_lastd[2];
   logic [AW-1:0] m_addr[2];
   logic [LW-1:0] m_wdata[2];
   int unsigned m_cnt[2];

   always begin
      @(negedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            bit act, ie, de;
            string p;
            p   = $sformatf("dp%0d", k);
            act = (m_owner[k] != 0);
            ie  = (m_owner[k] == 1) && resp_v[k];
            de  = (m_owner[k] == 2) && resp_v[k];
            chk({p, ".pmem_read"}, LW'(pr_v[k]), LW'(act && !m_wr[k]));
            chk({p, ".pmem_write"}, LW'(pw_v[k]), LW'(act && m_wr[k]));
            if (act) begin
               chk({p, ".pmem_addr"}, LW'(pa_v[k]), LW'(m_addr[k]));
               chk({p, ".pmem_wdata"}, pwd_v[k], m_wdata[k]);
            end
            chk({p, ".i_resp"}, LW'(ir_v[k]), LW'(ie));
            chk({p, ".d_resp"}, LW'(dr_v[k]), LW'(de));
            chk({p, ".i_rdata"}, ird_v[k], ie ? rdata_in_v[k] : '0);
            chk({p, ".d_rdata"}, drd_v[k], de ? rdata_in_v[k] : '0);
            chk({p, ".conflict_cnt"}, LW'(cnt_v[k]), LW'(m_cnt[k]));
            ic[k] += int'(ir_v[k]);
            dc[k] += int'(dr_v[k]);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_owner[k] = 0; m_rel[k] = 0; m_wr[k] = 0; m_lastd[k] = 0;
            m_addr[k] = '0; m_wdata[k] = '0; m_cnt[k] = 0;
         end else if (m_owner[k] != 0) begin
            if (resp_v[k]) begin
               m_lastd[k] = (m_owner[k] == 2);
               m_owner[k] = 0;
               m_rel[k]   = 1;
            end
         end else if (m_rel[k]) begin
            m_rel[k] = 0;
         end else begin
            bit dreq;
            dreq = d_read_v[k] | d_write_v[k];
            if (i_read_v[k] && dreq && m_cnt[k] < 65535) m_cnt[k]++;
            if (dreq && (k == 1 || !i_read_v[k] || !m_lastd[k])) begin
               m_owner[k] = 2; m_wr[k] = d_write_v[k];
               m_addr[k] = d_addr_v[k]; m_wdata[k] = d_wdata_v[k];
            end else if (i_read_v[k]) begin
               m_owner[k] = 1; m_wr[k] = 0;
               m_addr[k] = i_addr_v[k]; m_wdata[k] = '0;
            end
         end
      end
   end

   // Memory responder: waits for a command, then pulses pmem_resp lat cycles later.
   task automatic serve(input int k, input int lat, input logic [LW-1:0] data,
                        output logic [AW-1:0] addr, output logic [LW-1:0] cap_i,
                        output logic [LW-1:0] cap_d);
      int n = 0;
      while (!(pr_v[k] || pw_v[k]) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL serve_timeout dp%0d: no command after %0d cycles, required one", k, n);
         addr = '0; cap_i = '0; cap_d = '0;
         return;
      end
      addr = pa_v[k];
      repeat (lat) @(posedge clk);
      #1;
      resp_v[k] = 1'b1;
      rdata_in_v[k] = data;
      @(negedge clk);
      cap_i = ird_v[k];
      cap_d = drd_v[k];
      @(posedge clk); #1;
      resp_v[k] = 1'b0;
      rdata_in_v[k] = '0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   logic [AW-1:0] a;
   logic [LW-1:0] ci, cd;
   logic [AW-1:0] rr[3];

   initial begin
      rst = 1'b1;
      i_read_v = '0; d_read_v = '0; d_write_v = '0; resp_v = '0;
      i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; rdata_in_v = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pmem_read", LW'(pr_v[1]), '0);
      chk("rst_pmem_write", LW'(pw_v[1]), '0);
      chk("rst_conflict", LW'(cnt_v[1]), '0);
      chk("rst_i_rdata", ird_v[1], '0);
      rst = 1'b0;
      idle_cycle();

      // Single I read
      i_read_v[1] = 1'b1; i_addr_v[1] = 32'h0000_0060;
      idle_cycle();
      chk("t1_latency", LW'(pr_v[1]), LW'(1));
      chk("t1_addr", LW'(pa_v[1]), LW'(32'h60));
      serve(1, 4, {32{8'hA5}}, a, ci, cd);
      i_read_v[1] = 1'b0;
      chk("t1_i_rdata", ci, {32{8'hA5}});
      chk("t1_release_read", LW'(pr_v[1]), '0);
      chk("t1_i_resp_count", LW'(ic[1]), LW'(1));
      chk("t1_d_resp_count", LW'(dc[1]), '0);
      idle_cycle();

      // Contention with D priority
      i_read_v[1] = 1'b1; i_addr_v[1] = 32'h100;
      d_read_v[1] = 1'b1; d_addr_v[1] = 32'h200;
      serve(1, 2, {8{32'h1111_1111}}, a, ci, cd);
      d_read_v[1] = 1'b0;
      chk("t2_first_addr", LW'(a), LW'(32'h200));
      chk("t2_d_rdata", cd, {8{32'h1111_1111}});
      serve(1, 2, {8{32'h2222_2222}}, a, ci, cd);
      i_read_v[1] = 1'b0;
      chk("t2_second_addr", LW'(a), LW'(32'h100));
      chk("t2_i_rdata", ci, {8{32'h2222_2222}});
      chk("t2_conflict", LW'(cnt_v[1]), LW'(1));
      idle_cycle();

      // D writeback with address change mid-transaction
      d_write_v[1] = 1'b1; d_addr_v[1] = 32'h3C0; d_wdata_v[1] = {8{32'hDEAD_BEEF}};
      idle_cycle();
      chk("t4_write", LW'(pw_v[1]), LW'(1));
      chk("t4_no_read", LW'(pr_v[1]), '0);
      d_addr_v[1] = 32'h400; d_wdata_v[1] = '1;
      idle_cycle();
      chk("t4_addr_held", LW'(pa_v[1]), LW'(32'h3C0));
      chk("t4_wdata_held", pwd_v[1], {8{32'hDEAD_BEEF}});
      serve(1, 3, '0, a, ci, cd);
      d_write_v[1] = 1'b0;
      chk("t4_d_resp_count", LW'(dc[1]), LW'(2));
      idle_cycle();

      // Spurious pmem_resp in IDLE
      resp_v[1] = 1'b1; rdata_in_v[1] = '1;
      @(negedge clk);
      chk("t5_no_i_resp", LW'(ir_v[1]), '0);
      chk("t5_no_d_resp", LW'(dr_v[1]), '0);
      @(posedge clk); #1;
      resp_v[1] = 1'b0; rdata_in_v[1] = '0;
      i_read_v[1] = 1'b1; i_addr_v[1] = 32'h80;
      idle_cycle();
      chk("t5_still_idle", LW'(pr_v[1]), LW'(1));
      serve(1, 1, {8{32'h0BAD_F00D}}, a, ci, cd);
      i_read_v[1] = 1'b0;
      idle_cycle();

      // Read and write together: write wins
      d_read_v[1] = 1'b1; d_write_v[1] = 1'b1; d_addr_v[1] = 32'h500;
      d_wdata_v[1] = {8{32'h1234_5678}};
      idle_cycle();
      chk("t6_write", LW'(pw_v[1]), LW'(1));
      chk("t6_no_read", LW'(pr_v[1]), '0);
      serve(1, 1, '0, a, ci, cd);
      d_read_v[1] = 1'b0; d_write_v[1] = 1'b0;
      idle_cycle();

      // Round-robin with both held continuously
      i_read_v[0] = 1'b1; i_addr_v[0] = 32'h100;
      d_read_v[0] = 1'b1; d_addr_v[0] = 32'h200;
      for (int n = 0; n < 3; n++) begin
         serve(0, 1, {8{32'h0}} | LW'(n), a, ci, cd);
         rr[n] = a;
      end
      i_read_v[0] = 1'b0; d_read_v[0] = 1'b0;
      chk("t7_grant0", LW'(rr[0]), LW'(32'h200));
      chk("t7_grant1", LW'(rr[1]), LW'(32'h100));
      chk("t7_grant2", LW'(rr[2]), LW'(32'h200));
      chk("t7_conflict", LW'(cnt_v[0]), LW'(3));
      idle_cycle();

      // Asynchronous reset during D_BUSY
      d_write_v[1] = 1'b1; d_addr_v[1] = 32'h600; d_wdata_v[1] = {8{32'hCAFE_0001}};
      idle_cycle();
      chk("t8_write_start", LW'(pw_v[1]), LW'(1));
      @(posedge clk); #3;
      rst = 1'b1;
      d_write_v[1] = 1'b0;
      #1;
      chk("t8_async_write", LW'(pw_v[1]), '0);
      chk("t8_async_read", LW'(pr_v[1]), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t8_conflict_cleared", LW'(cnt_v[1]), '0);
      i_read_v[1] = 1'b1; i_addr_v[1] = 32'h700;
      idle_cycle();
      chk("t8_fresh_read", LW'(pr_v[1]), LW'(1));
      chk("t8_fresh_addr", LW'(pa_v[1]), LW'(32'h700));
      serve(1, 2, {8{32'h7777_7777}}, a, ci, cd);
      i_read_v[1] = 1'b0;
      chk("t8_i_rdata", ci, {8{32'h7777_7777}});
      chk("t8_i_resp_total", LW'(ic[1]), LW'(4));
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
